drive_sequencer: RTL and testbench

- Takes the 4-bit debounced direction code from the magnetic-sensor switch block and sequences timed evasive drive maneuvers for the left and right motors.
- Arbitrates between three sources: front-contact events, rear-contact events and the default cruise command. Front events pre-empt.
- Sits between the sensor switch block and the motor driver outputs.

---
 rtl/drive_pkg.sv | 52 +++++
 rtl/seq_timer.sv | 30 +++
 rtl/drive_sequencer.sv | 152 +++++++++++++++
 tb/tb_drive_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared types and constants for the drive sequencer: FSM state encoding,
// pending-event encoding, motor command codes and contact direction codes.
package drive_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_BACKUP = 3'd2,
    S_TURN   = 3'd3,
    S_PAUSE  = 3'd4,
    S_ESCAPE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE  = 2'd0,
    PEND_FRONT = 2'd1,
    PEND_REAR  = 2'd2
  } pend_t;

  localparam logic [1:0] MOT_STOP  = 2'b00;
  localparam logic [1:0] MOT_FWD   = 2'b01;
  localparam logic [1:0] MOT_REV   = 2'b10;
  localparam logic [1:0] MOT_BRAKE = 2'b11;

  localparam logic [3:0] DIR_FRONT = 4'b0011;
  localparam logic [3:0] DIR_REAR  = 4'b1100;

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] r;
  } motor_t;

  // Motor pair driven while sitting in a given state.
  function automatic motor_t motor_of(state_t s);
    motor_t m;
    case (s)
      S_FWD:    m = '{l: MOT_FWD,   r: MOT_FWD};
      S_BACKUP: m = '{l: MOT_REV,   r: MOT_REV};
      S_TURN:   m = '{l: MOT_FWD,   r: MOT_REV};
      S_PAUSE:  m = '{l: MOT_BRAKE, r: MOT_BRAKE};
      S_ESCAPE: m = '{l: MOT_FWD,   r: MOT_FWD};
      default:  m = '{l: MOT_STOP,  r: MOT_STOP};
    endcase
    return m;
  endfunction

  // True for the timed maneuver states.
  function automatic logic is_busy(state_t s);
    return (s == S_BACKUP) || (s == S_TURN) || (s == S_PAUSE) || (s == S_ESCAPE);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Free-running state timer: cleared on request, otherwise counts up.
// done flags the last cycle of a window of 'limit' cycles.
module seq_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  // Count cycles since the last clear.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign done = (r_count == (limit - 1'b1));

endmodule

// File: rtl/drive_sequencer.sv
// Evasive drive sequencer: turns debounced contact codes into timed motor
// maneuvers (backup/turn/pause after a front hit, forward escape after a
// rear hit), with a one-deep pending slot for events during a maneuver.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int BACKUP_CYC = 12_500_000,
  parameter int TURN_CYC   = 6_250_000,
  parameter int PAUSE_CYC  = 2_500_000,
  parameter int ESCAPE_CYC = 12_500_000,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] dir,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic [2:0] state,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  state_t           r_state;
  pend_t            r_pend;
  motor_t           r_mot;
  logic             r_busy;
  logic [7:0]       r_drop_cnt;
  logic [3:0]       r_dir_q;

  state_t           w_next;
  pend_t            w_pend_next;
  logic             w_drop;
  logic             w_front_ev;
  logic             w_rear_ev;
  logic             w_done;
  logic             w_tmr_clr;
  logic [CNT_W-1:0] w_limit;

  // Edge-detect the contact codes; nothing is seen while disabled.
  assign w_front_ev = enable && (dir == DIR_FRONT) && (r_dir_q != DIR_FRONT);
  assign w_rear_ev  = enable && (dir == DIR_REAR)  && (r_dir_q != DIR_REAR);

  // Select the dwell length of the state currently being timed.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_limit = CNT_W'(BACKUP_CYC);
    case (r_state)
      S_TURN:   w_limit = CNT_W'(TURN_CYC);
      S_PAUSE:  w_limit = CNT_W'(PAUSE_CYC);
      S_ESCAPE: w_limit = CNT_W'(ESCAPE_CYC);
      default:  ;
    endcase
  end

  // Timer restarts on every state entry and is held at zero while disabled.
  assign w_tmr_clr = !enable || (w_next != r_state);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_tmr_clr),
    .limit (w_limit),
    .done  (w_done)
  );

  // Next-state, pending-slot and drop decisions.
  always_comb begin
    w_next      = r_state;
    w_pend_next = r_pend;
    w_drop      = 1'b0;
    if (!enable) begin
      w_next      = S_IDLE;
      w_pend_next = PEND_NONE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_FWD;
        S_FWD: begin
          if (w_front_ev)     w_next = S_BACKUP;
          else if (w_rear_ev) w_next = S_ESCAPE;
        end
        S_ESCAPE: begin
          if (w_front_ev) begin
            w_next = S_BACKUP;
          end else begin
            w_drop = w_rear_ev;
            if (w_done) w_next = S_FWD;
          end
        end
        S_BACKUP, S_TURN, S_PAUSE: begin
          if ((r_state == S_PAUSE) && w_done && (w_front_ev || w_rear_ev)) begin
            // Event on the last pause cycle is serviced directly; front wins
            // and whatever was pending is displaced.
            w_drop      = (r_pend != PEND_NONE);
            w_next      = (w_front_ev || (r_pend == PEND_FRONT)) ? S_BACKUP : S_ESCAPE;
            w_pend_next = PEND_NONE;
          end else begin
            if (w_front_ev) begin
              w_pend_next = PEND_FRONT;
              w_drop      = (r_pend != PEND_NONE);
            end else if (w_rear_ev) begin
              if (r_pend == PEND_NONE) w_pend_next = PEND_REAR;
              else                     w_drop      = 1'b1;
            end
            if (w_done) begin
              case (r_state)
                S_BACKUP: w_next = S_TURN;
                S_TURN:   w_next = S_PAUSE;
                default: begin
                  w_pend_next = PEND_NONE;
                  if (r_pend == PEND_FRONT)     w_next = S_BACKUP;
                  else if (r_pend == PEND_REAR) w_next = S_ESCAPE;
                  else                          w_next = S_FWD;
                end
              endcase
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // FSM state and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pend     <= PEND_NONE;
      r_mot      <= '{l: MOT_STOP, r: MOT_STOP};
      r_busy     <= 1'b0;
      r_drop_cnt <= '0;
      r_dir_q    <= '0;
    end else begin
      r_dir_q <= dir;
      r_state <= w_next;
      r_pend  <= w_pend_next;
      r_mot   <= motor_of(w_next);
      r_busy  <= is_busy(w_next);
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign motor_l  = r_mot.l;
  assign motor_r  = r_mot.r;
  assign state    = r_state;
  assign busy     = r_busy;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer: a driver steps a behavioural model
// alongside the DUT and queues the expected outputs of each edge; a monitor
// pops and compares them shortly after that edge.
module tb_drive_sequencer;

  localparam int BK = 8;
  localparam int TN = 4;
  localparam int PS = 2;
  localparam int ES = 6;

  // Model state numbering follows the published encoding.
  localparam int IDLE = 0, FWD = 1, BACKUP = 2, TURN = 3, PAUSE = 4, ESCAPE = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] dir = 4'd0;
  logic [1:0] motor_l, motor_r;
  logic [2:0] state;
  logic       busy;
  logic [7:0] drop_cnt;

  drive_sequencer #(
    .BACKUP_CYC (BK),
    .TURN_CYC   (TN),
    .PAUSE_CYC  (PS),
    .ESCAPE_CYC (ES),
    .CNT_W      (25)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .dir      (dir),
    .motor_l  (motor_l),
    .motor_r  (motor_r),
    .state    (state),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int st;
    int ml;
    int mr;
    int bz;
    int drop;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model: remaining-cycle countdown per maneuver phase.
  int         m_state, m_left, m_pend, m_drop;
  logic [3:0] m_prev;
  int         ml_tab[6] = '{0, 1, 2, 1, 3, 1};
  int         mr_tab[6] = '{0, 1, 2, 2, 3, 1};

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int dur(int s);
    case (s)
      BACKUP:  return BK;
      TURN:    return TN;
      PAUSE:   return PS;
      ESCAPE:  return ES;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_state = IDLE; m_left = 0; m_pend = 0; m_drop = 0; m_prev = 4'd0;
  endtask

  task automatic m_enter(int s);
    m_state = s;
    m_left  = dur(s);
  endtask

  task automatic m_count_drop();
    if (m_drop < 255) m_drop++;
  endtask

  // One-deep pending slot: 1 = front, 2 = rear.
  task automatic m_latch(bit fe, bit re);
    if (fe) begin
      if (m_pend != 0) m_count_drop();
      m_pend = 1;
    end else if (re) begin
      if (m_pend == 0) m_pend = 2;
      else             m_count_drop();
    end
  endtask

  task automatic m_step(bit en, logic [3:0] d);
    bit fe, re;
    fe = en && (d == 4'b0011) && (m_prev != 4'b0011);
    re = en && (d == 4'b1100) && (m_prev != 4'b1100);
    m_prev = d;
    if (!en) begin
      m_state = IDLE; m_left = 0; m_pend = 0;
      return;
    end
    case (m_state)
      IDLE: m_enter(FWD);
      FWD: begin
        if (fe)      m_enter(BACKUP);
        else if (re) m_enter(ESCAPE);
      end
      ESCAPE: begin
        if (fe) m_enter(BACKUP);
        else begin
          if (re) m_count_drop();
          m_left--;
          if (m_left == 0) m_enter(FWD);
        end
      end
      BACKUP, TURN: begin
        m_latch(fe, re);
        m_left--;
        if (m_left == 0) m_enter(m_state == BACKUP ? TURN : PAUSE);
      end
      PAUSE: begin
        if (m_left == 1 && (fe || re)) begin
          if (m_pend != 0) m_count_drop();
          m_enter((fe || m_pend == 1) ? BACKUP : ESCAPE);
          m_pend = 0;
        end else begin
          m_latch(fe, re);
          m_left--;
          if (m_left == 0) begin
            m_enter(m_pend == 1 ? BACKUP : (m_pend == 2 ? ESCAPE : FWD));
            m_pend = 0;
          end
        end
      end
      default: m_enter(IDLE);
    endcase
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    e.st   = m_state;
    e.ml   = ml_tab[m_state];
    e.mr   = mr_tab[m_state];
    e.bz   = (m_state >= BACKUP) ? 1 : 0;
    e.drop = m_drop;
    return e;
  endfunction

  // Apply one cycle of stimulus and queue what the DUT must show after it.
  task automatic tick(bit en, logic [3:0] d);
    enable = en;
    dir    = d;
    m_step(en, d);
    exp_q.push_back(m_expect());
    @(posedge clk);
    #3;
  endtask

  // Monitor: compare queued expectations two time units after each edge.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",    int'(state),    e.st);
      check("motor_l",  int'(motor_l),  e.ml);
      check("motor_r",  int'(motor_r),  e.mr);
      check("busy",     int'(busy),     e.bz);
      check("drop_cnt", int'(drop_cnt), e.drop);
    end
  end

  task automatic check_reset_values(string tag);
    check({tag, "_state"},   int'(state),    0);
    check({tag, "_motor_l"}, int'(motor_l),  0);
    check({tag, "_motor_r"}, int'(motor_r),  0);
    check({tag, "_busy"},    int'(busy),     0);
    check({tag, "_drop"},    int'(drop_cnt), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin : driver
    int r;
    logic [3:0] d;
    m_reset();
    repeat (2) @(posedge clk);
    #3;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Cruise, then a front contact held for 20 cycles: exactly one maneuver.
    repeat (10) tick(1'b1, 4'd0);
    repeat (20) tick(1'b1, 4'b0011);
    repeat (8)  tick(1'b1, 4'd0);

    // Rear escape with a second rear hit dropped mid-escape.
    tick(1'b1, 4'b1100);
    repeat (2) tick(1'b1, 4'd0);
    tick(1'b1, 4'b1100);
    repeat (8) tick(1'b1, 4'd0);

    // Front pre-empts an escape in progress.
    tick(1'b1, 4'b1100);
    repeat (2) tick(1'b1, 4'd0);
    tick(1'b1, 4'b0011);
    repeat (16) tick(1'b1, 4'd0);

    // Pending front during backup; rear during turn is dropped.
    tick(1'b1, 4'b0011);
    repeat (2) tick(1'b1, 4'd0);
    tick(1'b1, 4'b0011);
    repeat (5) tick(1'b1, 4'd0);
    tick(1'b1, 4'b1100);
    repeat (30) tick(1'b1, 4'd0);

    // Disable during turn with a front pending; events while disabled ignored.
    tick(1'b1, 4'b0011);
    tick(1'b1, 4'd0);
    tick(1'b1, 4'b0011);
    repeat (7) tick(1'b1, 4'd0);
    tick(1'b0, 4'd0);
    tick(1'b0, 4'b0011);
    tick(1'b0, 4'd0);
    repeat (6) tick(1'b1, 4'd0);

    // Asynchronous reset mid-backup, between clock edges.
    tick(1'b1, 4'b0011);
    repeat (3) tick(1'b1, 4'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    m_reset();
    dir = 4'd0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) tick(1'b1, 4'd0);

    // Randomized traffic, occasional disable.
    repeat (600) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       d = 4'b0011;
        1:       d = 4'b1100;
        2:       d = 4'd0;
        default: d = 4'($urandom_range(0, 15));
      endcase
      tick($urandom_range(0, 19) != 0, d);
    end

    // Saturation: a toggling front contact produces well over 300 drops.
    repeat (1400) begin
      tick(1'b1, 4'b0011);
      tick(1'b1, 4'd0);
    end
    check("drop_sat", int'(drop_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
